inst_sequencer: RTL and testbench
=================================

Name: inst_sequencer

Overview:
- On-chip initiator for the core's 34-bit instruction bus. Replaces bench-driven stimulus for one kernel-position (kij) pass.
- Each pass runs in order: kernel xmem→L0, L0→PE weight load, intermission, activation xmem→L0, execute, drain, then OFIFO→pmem psum write-back.
- Sits between the top-level controller (start/kij/done) and core.inst. Consumes core.ofifo_valid.

Parameters:
- ROW, 8, PE rows = kernel words per pass.
- LEN_NIJ, 36, activation words per pass.
- LEN_KIJ, 9, number of legal kij values.
- W_BASE, 11'h400, xmem base address of kernel words.
- GAP_CYC, 10, idle cycles after weight load.
- DRAIN_CYC, 12, idle cycles after execute before OFIFO read.
- PMEM_BASE, 0, pmem base address for psums.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low; 0 = reset.
- start  in  1  one-cycle request to run one pass.
- kij  in  4  kernel position for the pass; sampled with start.
- ofifo_valid  in  1  from core; OFIFO holds a full row.
- inst  out  34  instruction word to core (registered).
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse at pass end.
- err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- inst field map:
  - [33] acc; [32] CEN_pmem; [31] WEN_pmem; [30:20] A_pmem
  - [19] CEN_xmem; [18] WEN_xmem; [17:7] A_xmem
  - [6] ofifo_rd; [5] ififo_wr; [4] ififo_rd; [3] l0_rd; [2] l0_wr; [1] execute; [0] load
- IDLE_INST = 34'h1_800C_0000: both CEN/WEN high, all other bits 0.
  - Any field not listed for a phase holds its IDLE_INST value.
  - acc, ififo_wr and ififo_rd are always 0.
- Reset (reset=0 at a clk edge):
  - state=IDLE, inst=IDLE_INST, busy=0, done=0, err=0, counters=0.
  - Takes effect from any state; a pass in progress is abandoned without a done pulse.
- Start acceptance:
  - Accepted only in IDLE with kij < LEN_KIJ; kij is latched.
  - If kij ≥ LEN_KIJ in IDLE: err pulses the next cycle and the FSM stays in IDLE.
  - start while busy: ignored, no err.
- Counter and output timing:
  - c is the per-phase cycle counter, 0-based.
  - The value listed for phase cycle c appears on inst during that cycle.
  - c=0 of K_L0 is the cycle after the accepted start edge.
- States, in order:
  - K_L0, ROW+1 cycles:
    - c<ROW: CEN_xmem=0, WEN_xmem=1, A_xmem=W_BASE+c.
    - l0_wr=1 for c=1..ROW, covering the 1-cycle SRAM read latency.
  - K_LOAD, ROW+1 cycles: l0_rd=1 for c<ROW; load=1 for c=1..ROW.
  - GAP, GAP_CYC cycles: IDLE_INST.
  - A_L0, LEN_NIJ+1 cycles:
    - c<LEN_NIJ: CEN_xmem=0, WEN_xmem=1, A_xmem=c.
    - l0_wr=1 for c=1..LEN_NIJ.
  - A_EXEC, LEN_NIJ+1 cycles: l0_rd=1 for c<LEN_NIJ; execute=1 for c=1..LEN_NIJ.
  - DRAIN, DRAIN_CYC cycles: IDLE_INST.
  - O_WAIT: IDLE_INST until ofifo_valid=1 is sampled; move to O_RD next cycle. No timeout.
  - O_RD, LEN_NIJ+1 cycles:
    - ofifo_rd=1 for c<LEN_NIJ.
    - c=1..LEN_NIJ: CEN_pmem=0, WEN_pmem=0, A_pmem=PMEM_BASE+kij*LEN_NIJ+(c-1).
    - ofifo_valid is ignored inside O_RD.
  - DONE, 1 cycle: done=1, inst=IDLE_INST, busy=1; next state IDLE.
- A_pmem arithmetic:
  - Computed in 11 bits and wraps modulo 2048.
  - Max with defaults: 8*36+35 = 323.
- Pass latency with defaults (ofifo_valid already high at O_WAIT entry):
  - 9+9+10+37+37+12+1+37+1 = 153 cycles from first K_L0 cycle to DONE inclusive.
- A new start is accepted the cycle after DONE (IDLE); back-to-back passes are allowed.

Test Plan:
- Reset: hold reset=0 for 3 cycles with start=1 → inst=34'h1_800C_0000, busy=0, done=0, err=0 throughout.
- Weight phase: start, kij=0 → K_L0 c=0..7 shows A_xmem=0x400..0x407 with CEN_xmem=0; l0_wr=1 exactly 8 cycles starting one cycle later; then load=1 exactly 8 cycles, lagging l0_rd by 1.
- Psum addressing: kij=3, ofifo_valid tied 1 → 36 pmem writes at A_pmem=108..143; done at cycle 153 after start; busy high for cycles 1..153.
- O_WAIT handshake: ofifo_valid held 0 for 20 cycles after DRAIN → inst stays IDLE_INST; O_RD begins the cycle after ofifo_valid rises; done delayed by exactly 20 cycles.
- Illegal / overlapping starts: kij=9 → err pulses once, busy stays 0; start pulsed mid-pass → ignored, pass completes unchanged, one done only.
- Mid-operation reset: reset=0 during A_EXEC c=10 → next cycle inst=IDLE_INST, execute=0, no done; a subsequent start with kij=8 completes normally at A_pmem=288..323.

Source files
------------

// File: rtl/inst_sequencer_if.sv
// Controller/core-facing bundle of the instruction sequencer: pass request,
// OFIFO status in, 34-bit instruction word and pass status out.
interface inst_sequencer_if;
  logic        start;
  logic [3:0]  kij;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, kij, ofifo_valid,
    input  inst, busy, done, err
  );

  modport slave (
    input  start, kij, ofifo_valid,
    output inst, busy, done, err
  );
endinterface

// File: rtl/inst_sequencer.sv
// Drives the core instruction bus through one kij pass: kernel load, weight
// load, activation load, execute, drain, then OFIFO-to-pmem psum write-back.
module inst_sequencer #(
  parameter int unsigned ROW       = 8,
  parameter int unsigned LEN_NIJ   = 36,
  parameter int unsigned LEN_KIJ   = 9,
  parameter logic [10:0] W_BASE    = 11'h400,
  parameter int unsigned GAP_CYC   = 10,
  parameter int unsigned DRAIN_CYC = 12,
  parameter logic [10:0] PMEM_BASE = 11'd0
) (
  input logic              clk,
  input logic              reset,
  inst_sequencer_if.slave  bus
);

  localparam logic [33:0] IDLE_INST  = 34'h1_800C_0000;
  localparam logic [5:0]  ROW_C      = 6'(ROW);
  localparam logic [5:0]  NIJ_C      = 6'(LEN_NIJ);
  localparam logic [5:0]  GAP_LAST   = 6'(GAP_CYC - 1);
  localparam logic [5:0]  DRAIN_LAST = 6'(DRAIN_CYC - 1);
  localparam logic [4:0]  KIJ_LIM    = 5'(LEN_KIJ);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_K_L0   = 4'd1,
    S_K_LOAD = 4'd2,
    S_GAP    = 4'd3,
    S_A_L0   = 4'd4,
    S_A_EXEC = 4'd5,
    S_DRAIN  = 4'd6,
    S_O_WAIT = 4'd7,
    S_O_RD   = 4'd8,
    S_DONE   = 4'd9
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [3:0]  kij_q, kij_d;
  logic [33:0] inst_q;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // Strobes trail the SRAM/L0 read by one cycle to cover the read latency.
  function automatic logic [33:0] inst_for(state_e s, logic [5:0] c, logic [3:0] k);
    logic [33:0] w;
    w = IDLE_INST;
    case (s)
      S_K_L0: begin
        if (c < ROW_C) begin
          w[19]   = 1'b0;
          w[17:7] = W_BASE + 11'(c);
        end
        w[2] = (c != 6'd0);
      end
      S_K_LOAD: begin
        w[3] = (c < ROW_C);
        w[0] = (c != 6'd0);
      end
      S_A_L0: begin
        if (c < NIJ_C) begin
          w[19]   = 1'b0;
          w[17:7] = 11'(c);
        end
        w[2] = (c != 6'd0);
      end
      S_A_EXEC: begin
        w[3] = (c < NIJ_C);
        w[1] = (c != 6'd0);
      end
      S_O_RD: begin
        w[6] = (c < NIJ_C);
        if (c != 6'd0) begin
          w[32]    = 1'b0;
          w[31]    = 1'b0;
          w[30:20] = PMEM_BASE + 11'(k) * 11'(LEN_NIJ) + 11'(c) - 11'd1;
        end
      end
      default: w = IDLE_INST;
    endcase
    return w;
  endfunction

  // Next-state, phase counter and status-pulse decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 6'd1;
    kij_d   = kij_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = 6'd0;
        if (bus.start) begin
          if ({1'b0, bus.kij} < KIJ_LIM) begin
            state_d = S_K_L0;
            kij_d   = bus.kij;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_K_L0: begin
        if (cnt_q == ROW_C) begin state_d = S_K_LOAD; cnt_d = 6'd0; end
        else begin state_d = S_K_L0; end
      end
      S_K_LOAD: begin
        if (cnt_q == ROW_C) begin state_d = S_GAP; cnt_d = 6'd0; end
        else begin state_d = S_K_LOAD; end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin state_d = S_A_L0; cnt_d = 6'd0; end
        else begin state_d = S_GAP; end
      end
      S_A_L0: begin
        if (cnt_q == NIJ_C) begin state_d = S_A_EXEC; cnt_d = 6'd0; end
        else begin state_d = S_A_L0; end
      end
      S_A_EXEC: begin
        if (cnt_q == NIJ_C) begin state_d = S_DRAIN; cnt_d = 6'd0; end
        else begin state_d = S_A_EXEC; end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin state_d = S_O_WAIT; cnt_d = 6'd0; end
        else begin state_d = S_DRAIN; end
      end
      S_O_WAIT: begin
        cnt_d = 6'd0;
        if (bus.ofifo_valid) begin state_d = S_O_RD; end
        else begin state_d = S_O_WAIT; end
      end
      S_O_RD: begin
        if (cnt_q == NIJ_C) begin
          state_d = S_DONE;
          cnt_d   = 6'd0;
          done_d  = 1'b1;
        end else begin
          state_d = S_O_RD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; inst is pre-decoded from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      kij_q   <= 4'd0;
      inst_q  <= IDLE_INST;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kij_q   <= kij_d;
      inst_q  <= inst_for(state_d, cnt_d, kij_d);
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.inst = inst_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer: a timeline model overlays each
// phase's bus activity onto idle cycles and is compared cycle by cycle.
module tb_inst_sequencer;

  localparam int          ROW   = 8;
  localparam int          NIJ   = 36;
  localparam int          GAP   = 10;
  localparam int          DRAIN = 12;
  localparam logic [10:0] WB    = 11'h400;
  localparam logic [33:0] IDLE  = 34'h1_800C_0000;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  inst_sequencer_if bus ();

  inst_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  logic [33:0] exp_tl   [0:255];
  int          m_len;
  logic [33:0] obs_inst [0:255];
  logic        obs_busy [0:255];
  logic        obs_done [0:255];
  logic        obs_err  [0:255];

  // Expected instruction per cycle of a pass; cycle 1 is the first after start.
  task automatic model_pass(input int kij_v, input int r);
    int t_kld, t_gap, t_al0, t_ex, t_dr, t_ow, t_ord, extra;
    t_kld = 1 + ROW + 1;
    t_gap = t_kld + ROW + 1;
    t_al0 = t_gap + GAP;
    t_ex  = t_al0 + NIJ + 1;
    t_dr  = t_ex + NIJ + 1;
    t_ow  = t_dr + DRAIN;
    extra = (r > t_ow) ? r - t_ow : 0;
    t_ord = t_ow + 1 + extra;
    m_len = t_ord + NIJ + 1;
    for (int i = 0; i < 256; i++) exp_tl[i] = IDLE;
    for (int i = 0; i < ROW; i++) begin
      exp_tl[1 + i][19]     = 1'b0;
      exp_tl[1 + i][17:7]   = WB + 11'(i);
      exp_tl[2 + i][2]      = 1'b1;
      exp_tl[t_kld + i][3]  = 1'b1;
      exp_tl[t_kld + 1 + i][0] = 1'b1;
    end
    for (int i = 0; i < NIJ; i++) begin
      exp_tl[t_al0 + i][19]    = 1'b0;
      exp_tl[t_al0 + i][17:7]  = 11'(i);
      exp_tl[t_al0 + 1 + i][2] = 1'b1;
      exp_tl[t_ex + i][3]      = 1'b1;
      exp_tl[t_ex + 1 + i][1]  = 1'b1;
      exp_tl[t_ord + i][6]     = 1'b1;
      exp_tl[t_ord + 1 + i][32]    = 1'b0;
      exp_tl[t_ord + 1 + i][31]    = 1'b0;
      exp_tl[t_ord + 1 + i][30:20] = 11'((kij_v * NIJ + i) % 2048);
    end
  endtask

  // Issue start, then capture ncyc cycles while driving ofifo_valid/start/reset.
  task automatic run_pass(input int kij_v, input int r, input int ms, input int ms_kij,
                          input int rst_cyc, input int ncyc);
    @(negedge clk);
    bus.start = 1'b1;
    bus.kij = 4'(kij_v);
    bus.ofifo_valid = (r <= 0);
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      obs_inst[n] = bus.inst;
      obs_busy[n] = bus.busy;
      obs_done[n] = bus.done;
      obs_err[n]  = bus.err;
      bus.start = (n == ms);
      bus.kij = (n == ms) ? 4'(ms_kij) : 4'(kij_v);
      bus.ofifo_valid = (n >= r);
      reset = (n == rst_cyc) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b1;
    bus.kij = 4'd2;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      vec_cnt++;
      if (bus.inst !== IDLE || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
        miss_cnt++;
        $display("FAIL reset cyc %0d: got inst=%h b/d/e=%b%b%b want inst=%h b/d/e=000",
                 n, bus.inst, bus.busy, bus.done, bus.err, IDLE);
      end
    end
    reset = 1'b1;
    bus.start = 1'b0;
  endtask

  task automatic test_weight_phase();
    int n_wr, first_wr, n_ld, first_ld, first_rd;
    model_pass(0, 0);
    run_pass(0, 0, -1, 0, -1, m_len + 1);
    for (int n = 1; n <= m_len + 1; n++) begin
      vec_cnt++;
      if (obs_inst[n] !== exp_tl[n] || obs_busy[n] !== (n <= m_len) ||
          obs_done[n] !== (n == m_len) || obs_err[n] !== 1'b0) begin
        miss_cnt++;
        $display("FAIL weight_tl cyc %0d: got inst=%h b/d/e=%b%b%b want inst=%h busy=%b done=%b",
                 n, obs_inst[n], obs_busy[n], obs_done[n], obs_err[n], exp_tl[n], n <= m_len, n == m_len);
      end
    end
    n_wr = 0; first_wr = -1; n_ld = 0; first_ld = -1; first_rd = -1;
    for (int n = 1; n <= 28; n++) begin
      if (obs_inst[n][2]) begin n_wr++; if (first_wr < 0) first_wr = n; end
      if (obs_inst[n][0]) begin n_ld++; if (first_ld < 0) first_ld = n; end
      if (obs_inst[n][3] && first_rd < 0) first_rd = n;
    end
    vec_cnt++;
    if (obs_inst[1][19] !== 1'b0 || obs_inst[1][17:7] !== 11'h400 || obs_inst[8][17:7] !== 11'h407) begin
      miss_cnt++;
      $display("FAIL weight_addr: got first=%h last=%h cen=%b want 400/407 cen=0",
               obs_inst[1][17:7], obs_inst[8][17:7], obs_inst[1][19]);
    end
    vec_cnt++;
    if (n_wr !== 8 || first_wr !== 2 || n_ld !== 8 || first_rd !== 10 || first_ld !== 11) begin
      miss_cnt++;
      $display("FAIL weight_strobes: got wr=%0d@%0d rd@%0d ld=%0d@%0d want wr=8@2 rd@10 ld=8@11",
               n_wr, first_wr, first_rd, n_ld, first_ld);
    end
  endtask

  task automatic test_psum_addr();
    int n_pw, a_first, a_last, d_cyc, n_busy;
    model_pass(3, 0);
    run_pass(3, 0, -1, 0, -1, m_len + 1);
    n_pw = 0; a_first = -1; a_last = -1; d_cyc = -1; n_busy = 0;
    for (int n = 1; n <= m_len + 1; n++) begin
      vec_cnt++;
      if (obs_inst[n] !== exp_tl[n] || obs_busy[n] !== (n <= m_len) ||
          obs_done[n] !== (n == m_len) || obs_err[n] !== 1'b0) begin
        miss_cnt++;
        $display("FAIL psum_tl cyc %0d: got inst=%h b/d/e=%b%b%b want inst=%h",
                 n, obs_inst[n], obs_busy[n], obs_done[n], obs_err[n], exp_tl[n]);
      end
      if (obs_inst[n][32] === 1'b0) begin
        n_pw++;
        if (a_first < 0) a_first = int'(obs_inst[n][30:20]);
        a_last = int'(obs_inst[n][30:20]);
      end
      if (obs_done[n] === 1'b1 && d_cyc < 0) d_cyc = n;
      if (obs_busy[n] === 1'b1) n_busy++;
    end
    vec_cnt++;
    if (n_pw !== 36 || a_first !== 108 || a_last !== 143) begin
      miss_cnt++;
      $display("FAIL psum_addr: got %0d writes %0d..%0d want 36 writes 108..143", n_pw, a_first, a_last);
    end
    vec_cnt++;
    if (d_cyc !== 153 || n_busy !== 153) begin
      miss_cnt++;
      $display("FAIL psum_latency: got done@%0d busy=%0d want done@153 busy=153", d_cyc, n_busy);
    end
  endtask

  task automatic test_owait();
    int k, d_cyc;
    k = $urandom_range(8, 0);
    model_pass(k, 135);
    run_pass(k, 135, -1, 0, -1, m_len + 1);
    d_cyc = -1;
    for (int n = 1; n <= m_len + 1; n++) begin
      vec_cnt++;
      if (obs_inst[n] !== exp_tl[n] || obs_busy[n] !== (n <= m_len) ||
          obs_done[n] !== (n == m_len) || obs_err[n] !== 1'b0) begin
        miss_cnt++;
        $display("FAIL owait_tl cyc %0d: got inst=%h b/d/e=%b%b%b want inst=%h",
                 n, obs_inst[n], obs_busy[n], obs_done[n], obs_err[n], exp_tl[n]);
      end
      if (obs_done[n] === 1'b1 && d_cyc < 0) d_cyc = n;
    end
    vec_cnt++;
    if (d_cyc !== 173) begin
      miss_cnt++;
      $display("FAIL owait_delay: got done@%0d want done@173", d_cyc);
    end
  endtask

  task automatic test_illegal();
    int k;
    for (int it = 0; it < 4; it++) begin
      k = $urandom_range(15, 9);
      run_pass(k, 0, -1, 0, -1, 3);
      for (int n = 1; n <= 3; n++) begin
        vec_cnt++;
        if (obs_inst[n] !== IDLE || obs_busy[n] !== 1'b0 || obs_done[n] !== 1'b0 ||
            obs_err[n] !== (n == 1)) begin
          miss_cnt++;
          $display("FAIL illegal kij=%0d cyc %0d: got inst=%h b/d/e=%b%b%b want inst=%h err=%b",
                   k, n, obs_inst[n], obs_busy[n], obs_done[n], obs_err[n], IDLE, n == 1);
        end
      end
    end
  endtask

  task automatic test_overlap();
    int k, ms, n_done;
    k = $urandom_range(8, 0);
    ms = $urandom_range(153, 1);
    model_pass(k, 0);
    run_pass(k, 0, ms, $urandom_range(15, 0), -1, m_len + 2);
    n_done = 0;
    for (int n = 1; n <= m_len + 2; n++) begin
      vec_cnt++;
      if (obs_inst[n] !== exp_tl[n] || obs_busy[n] !== (n <= m_len) ||
          obs_done[n] !== (n == m_len) || obs_err[n] !== 1'b0) begin
        miss_cnt++;
        $display("FAIL overlap ms=%0d cyc %0d: got inst=%h b/d/e=%b%b%b want inst=%h",
                 ms, n, obs_inst[n], obs_busy[n], obs_done[n], obs_err[n], exp_tl[n]);
      end
      if (obs_done[n] === 1'b1) n_done++;
    end
    vec_cnt++;
    if (n_done !== 1) begin
      miss_cnt++;
      $display("FAIL overlap_done: got %0d done pulses want 1", n_done);
    end
  endtask

  task automatic test_mid_reset();
    int k, a_first, a_last;
    k = $urandom_range(8, 0);
    model_pass(k, 0);
    run_pass(k, 0, -1, 0, 76, 80);
    for (int n = 1; n <= 80; n++) begin
      vec_cnt++;
      if (obs_inst[n] !== ((n <= 76) ? exp_tl[n] : IDLE) || obs_busy[n] !== (n <= 76) ||
          obs_done[n] !== 1'b0 || obs_err[n] !== 1'b0) begin
        miss_cnt++;
        $display("FAIL midreset cyc %0d: got inst=%h b/d/e=%b%b%b want inst=%h busy=%b",
                 n, obs_inst[n], obs_busy[n], obs_done[n], obs_err[n],
                 (n <= 76) ? exp_tl[n] : IDLE, n <= 76);
      end
    end
    model_pass(8, 0);
    run_pass(8, 0, -1, 0, -1, m_len + 1);
    a_first = -1; a_last = -1;
    for (int n = 1; n <= m_len + 1; n++) begin
      vec_cnt++;
      if (obs_inst[n] !== exp_tl[n] || obs_busy[n] !== (n <= m_len) ||
          obs_done[n] !== (n == m_len) || obs_err[n] !== 1'b0) begin
        miss_cnt++;
        $display("FAIL after_reset cyc %0d: got inst=%h b/d/e=%b%b%b want inst=%h",
                 n, obs_inst[n], obs_busy[n], obs_done[n], obs_err[n], exp_tl[n]);
      end
      if (obs_inst[n][32] === 1'b0) begin
        if (a_first < 0) a_first = int'(obs_inst[n][30:20]);
        a_last = int'(obs_inst[n][30:20]);
      end
    end
    vec_cnt++;
    if (a_first !== 288 || a_last !== 323) begin
      miss_cnt++;
      $display("FAIL kij8_addr: got %0d..%0d want 288..323", a_first, a_last);
    end
  endtask

  task automatic test_back_to_back();
    int k, r;
    for (int it = 0; it < 5; it++) begin
      k = $urandom_range(8, 0);
      r = $urandom_range(160, 0);
      model_pass(k, r);
      run_pass(k, r, -1, 0, -1, m_len);
      for (int n = 1; n <= m_len; n++) begin
        vec_cnt++;
        if (obs_inst[n] !== exp_tl[n] || obs_busy[n] !== 1'b1 ||
            obs_done[n] !== (n == m_len) || obs_err[n] !== 1'b0) begin
          miss_cnt++;
          $display("FAIL b2b pass %0d kij=%0d r=%0d cyc %0d: got inst=%h b/d/e=%b%b%b want inst=%h",
                   it, k, r, n, obs_inst[n], obs_busy[n], obs_done[n], obs_err[n], exp_tl[n]);
        end
      end
    end
    @(negedge clk);
    vec_cnt++;
    if (bus.inst !== IDLE || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miss_cnt++;
      $display("FAIL b2b_idle: got inst=%h busy=%b done=%b want inst=%h busy=0 done=0",
               bus.inst, bus.busy, bus.done, IDLE);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.kij = 4'd0;
    bus.ofifo_valid = 1'b0;
    test_reset();
    test_weight_phase();
    test_psum_addr();
    test_owait();
    test_illegal();
    test_overlap();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
